// File: rtl/tod_pkg.sv
// Shared types and constants for the time-of-day counter: field and FSM
// encodings, stage limits and widths, and the load range check.
package tod_pkg;

  typedef enum logic [1:0] {
    SEC = 2'd0,
    MIN = 2'd1,
    HR  = 2'd2,
    ALM = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    ACK      = 2'd2,
    ACK_WAIT = 2'd3
  } state_e;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  // The alarm field carries minutes, so it shares the minutes limit.
  function automatic logic val_ok(input field_e f, input logic [5:0] v,
                                  input logic alm_en);
    case (f)
      SEC:     val_ok = (v <= 6'(SEC_MAX));
      MIN:     val_ok = (v <= 6'(MIN_MAX));
      HR:      val_ok = (v <= 6'(HR_MAX));
      default: val_ok = alm_en && (v <= 6'(MIN_MAX));
    endcase
  endfunction

endpackage

// File: rtl/tod_stage.sv
// Modulo-N counter stage with synchronous load and a combinational carry
// out that enables the next stage in the cascade.
module tod_stage #(
  parameter int W = 6,
  parameter int N = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         co
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign co = ce && (q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (ce) begin
      q <= co ? '0 : q + W'(1);
    end
  end

endmodule

// File: rtl/tod_counter_ctl.sv
// Time-of-day controller: sec/min/hr cascade, req/ack load handshake with a
// one-deep pending tick. Optional alarm compare built when TOD_ALARM_EN is defined.
module tod_counter_ctl
  import tod_pkg::*;
#(
  parameter int TICK_GAP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             set_req,
  input  logic [1:0]       set_field,
  input  logic [5:0]       set_val,
  output logic             set_ack,
  output logic             set_err,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic             day_wrap,
  output logic             alarm
);

`ifdef TOD_ALARM_EN
  localparam logic ALM_EN = 1'b1;
`else
  localparam logic ALM_EN = 1'b0;
`endif

  state_e state;
  logic   tick_pend;
  logic   in_run;
  logic   tick_eff;
  field_e field;
  logic   legal;
  logic   do_load;
  logic   co_sec, co_min, co_hr;

  assign field   = field_e'(set_field);
  assign legal   = val_ok(field, set_val, ALM_EN);
  assign do_load = (state == LOAD) && legal;

  // Counting is frozen in LOAD/ACK so a load never races an increment;
  // the frozen tick is replayed from tick_pend once the load has landed.
  assign in_run   = (state == IDLE) || (state == ACK_WAIT);
  assign tick_eff = in_run && (tick || tick_pend);

  tod_stage #(.W(SEC_W), .N(SEC_MAX + 1)) u_sec (
    .clk (clk),
    .rst (rst),
    .ce  (tick_eff),
    .ld  (do_load && (field == SEC)),
    .d   (set_val[SEC_W-1:0]),
    .q   (sec),
    .co  (co_sec)
  );

  tod_stage #(.W(MIN_W), .N(MIN_MAX + 1)) u_min (
    .clk (clk),
    .rst (rst),
    .ce  (co_sec),
    .ld  (do_load && (field == MIN)),
    .d   (set_val[MIN_W-1:0]),
    .q   (min),
    .co  (co_min)
  );

  tod_stage #(.W(HR_W), .N(HR_MAX + 1)) u_hr (
    .clk (clk),
    .rst (rst),
    .ce  (co_min),
    .ld  (do_load && (field == HR)),
    .d   (set_val[HR_W-1:0]),
    .q   (hr),
    .co  (co_hr)
  );

  // Handshake: set_req rises and holds; set_ack/set_err pulse once in ACK;
  // set_req must drop (seen in ACK_WAIT) before the next request is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tick_pend <= 1'b0;
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      set_ack  <= 1'b0;
      set_err  <= 1'b0;
      day_wrap <= co_hr;
      case (state)
        IDLE: if (set_req) state <= LOAD;
        LOAD: begin
          set_ack <= 1'b1;
          set_err <= !legal;
          state   <= ACK;
        end
        ACK:      state <= ACK_WAIT;
        ACK_WAIT: if (!set_req) state <= IDLE;
        default:  state <= IDLE;
      endcase
      if (in_run) begin
        tick_pend <= 1'b0;
      end else if (tick) begin
        tick_pend <= 1'b1;
      end
    end
  end

`ifdef TOD_ALARM_EN
  logic [5:0]       alm_stage;
  logic [5:0]       alm_hr;
  logic [MIN_W-1:0] alm_min;
  logic [MIN_W-1:0] min_nxt;
  logic [HR_W-1:0]  hr_nxt;

  // Values the counters take on the minute rollover, so the pulse lines
  // up with the display showing hh:mm:00.
  assign min_nxt = (min == MIN_W'(MIN_MAX)) ? '0 : min + MIN_W'(1);
  assign hr_nxt  = co_min ? ((hr == HR_W'(HR_MAX)) ? '0 : hr + HR_W'(1)) : hr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alm_stage <= '0;
      alm_hr    <= '0;
      alm_min   <= '0;
      alarm     <= 1'b0;
    end else begin
      alarm <= co_sec && (min_nxt == alm_min) && ({1'b0, hr_nxt} == alm_hr);
      if (do_load && (field == ALM)) begin
        alm_stage <= set_val;
        alm_hr    <= alm_stage;
        alm_min   <= set_val[MIN_W-1:0];
      end
    end
  end
`else
  assign alarm = 1'b0;
`endif

  for (genvar g = 1; g < TICK_GAP; g++) begin : g_tick_gap
    a_tick_gap: assert property (@(posedge clk) disable iff (rst) tick |-> !$past(tick, g));
  end

endmodule

// File: tb/tb_tod_counter_ctl.sv
// Self-checking bench for tod_counter_ctl: tick cascade, day wrap, load
// handshake, range errors, deferred tick, reset mid-handshake, alarm field.
module tb_tod_counter_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       set_req = 1'b0;
  logic [1:0] set_field = 2'd0;
  logic [5:0] set_val = 6'd0;
  logic       set_ack, set_err, day_wrap, alarm;
  logic [5:0] sec, min;
  logic [4:0] hr;

  int errors = 0;
  int checks = 0;
  int tsec = 0;
  logic [0:0] exp_q[$];
  int ack_cnt = 0, wrap_cnt = 0, alarm_cnt = 0;
  int wrap_at = -1, alarm_at = -1;

  always #5 clk = ~clk;

  tod_counter_ctl #(.TICK_GAP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .set_req   (set_req),
    .set_field (set_field),
    .set_val   (set_val),
    .set_ack   (set_ack),
    .set_err   (set_err),
    .sec       (sec),
    .min       (min),
    .hr        (hr),
    .day_wrap  (day_wrap),
    .alarm     (alarm)
  );

  function automatic logic [16:0] hms(input int t);
    hms = {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)};
  endfunction

  function automatic int model_load(input int t, input logic [1:0] f, input int v);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    case (f)
      2'd0: s = v;
      2'd1: m = v;
      2'd2: h = v;
      default: ;
    endcase
    return h * 3600 + m * 60 + s;
  endfunction

  always @(posedge clk) begin
    #2;
    if (set_ack) ack_cnt++;
    if (day_wrap) begin
      wrap_cnt++;
      wrap_at = hr * 3600 + min * 60 + sec;
    end
    if (alarm) begin
      alarm_cnt++;
      alarm_at = hr * 3600 + min * 60 + sec;
    end
  end

  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    tsec = (tsec + 1) % 86400;
    checks++;
    if ({hr, min, sec} !== hms(tsec)) begin
      errors++;
      $display("FAIL tick_count: got %0d:%0d:%0d expected %0d", hr, min, sec, tsec);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_set(input logic [1:0] f, input logic [5:0] v, input logic e,
                        input logic with_tick);
    int n;
    logic [0:0] exp_e;
    @(negedge clk);
    set_field = f;
    set_val   = v;
    set_req   = 1'b1;
    exp_q.push_back(e);
    if (!e) tsec = model_load(tsec, f, int'(v));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      tick = (with_tick && n == 1);
    end while (!set_ack && n < 8);
    tick = 1'b0;
    exp_e = exp_q.pop_front();
    checks++;
    if (!set_ack || n != 2) begin
      errors++;
      $display("FAIL ack_latency: got ack=%0b after %0d cycles expected 1 after 2", set_ack, n);
    end
    checks++;
    if (set_err !== exp_e) begin
      errors++;
      $display("FAIL set_err f=%0d v=%0d: got %0b expected %0b", f, v, set_err, exp_e);
    end
    checks++;
    if ({hr, min, sec} !== hms(tsec)) begin
      errors++;
      $display("FAIL load_value: got %0d:%0d:%0d expected %0d", hr, min, sec, tsec);
    end
    set_req = 1'b0;
    if (with_tick) begin
      tsec = (tsec + 1) % 86400;
      repeat (2) @(negedge clk);
      checks++;
      if ({hr, min, sec} !== hms(tsec)) begin
        errors++;
        $display("FAIL deferred_tick: got %0d:%0d:%0d expected %0d", hr, min, sec, tsec);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({hr, min, sec, set_ack, set_err, day_wrap, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0d:%0d:%0d ack=%0b err=%0b wrap=%0b alarm=%0b expected all 0",
               hr, min, sec, set_ack, set_err, day_wrap, alarm);
    end
    rst = 1'b0;
    tsec = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ticks();
    int a0;
    a0 = ack_cnt;
    repeat (61) pulse_tick();
    checks++;
    if ({hr, min, sec} !== {5'd0, 6'd1, 6'd1}) begin
      errors++;
      $display("FAIL ticks_61: got %0d:%0d:%0d expected 0:1:1", hr, min, sec);
    end
    checks++;
    if (ack_cnt != a0) begin
      errors++;
      $display("FAIL ticks_no_ack: got %0d acks expected 0", ack_cnt - a0);
    end
  endtask

  task automatic test_day_wrap();
    int w0;
    do_set(2'd2, 6'd23, 1'b0, 1'b0);
    do_set(2'd1, 6'd59, 1'b0, 1'b0);
    do_set(2'd0, 6'd58, 1'b0, 1'b0);
    w0 = wrap_cnt;
    pulse_tick();
    checks++;
    if (wrap_cnt != w0) begin
      errors++;
      $display("FAIL wrap_early: got %0d pulses expected 0", wrap_cnt - w0);
    end
    pulse_tick();
    checks++;
    if (wrap_cnt != w0 + 1) begin
      errors++;
      $display("FAIL wrap_count: got %0d pulses expected 1", wrap_cnt - w0);
    end
    checks++;
    if (wrap_at != 0) begin
      errors++;
      $display("FAIL wrap_time: got %0d expected 0", wrap_at);
    end
  endtask

  task automatic test_range_err();
    do_set(2'd0, 6'd60, 1'b1, 1'b0);
    do_set(2'd1, 6'd63, 1'b1, 1'b0);
    do_set(2'd2, 6'd24, 1'b1, 1'b0);
    do_set(2'd2, 6'd0, 1'b0, 1'b0);
  endtask

  task automatic test_deferred();
    do_set(2'd0, 6'd59, 1'b0, 1'b1);
    checks++;
    if (sec !== 6'd0) begin
      errors++;
      $display("FAIL deferred_sec: got %0d expected 0", sec);
    end
  endtask

  task automatic test_back_to_back();
    int a0;
    logic got;
    logic [0:0] exp_e;
    @(negedge clk);
    set_field = 2'd0;
    set_val   = 6'd30;
    set_req   = 1'b1;
    exp_q.push_back(1'b0);
    tsec = model_load(tsec, 2'd0, 30);
    a0 = ack_cnt;
    got = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (set_ack && !got) begin
        got = 1'b1;
        exp_e = exp_q.pop_front();
        checks++;
        if (set_err !== exp_e) begin
          errors++;
          $display("FAIL hold_err: got %0b expected %0b", set_err, exp_e);
        end
      end
    end
    if (!got) void'(exp_q.pop_front());
    checks++;
    if (ack_cnt - a0 != 1) begin
      errors++;
      $display("FAIL hold_single_ack: got %0d acks expected 1", ack_cnt - a0);
    end
    checks++;
    if (sec !== 6'd30) begin
      errors++;
      $display("FAIL hold_value: got %0d expected 30", sec);
    end
    set_req = 1'b0;
    @(negedge clk);
    do_set(2'd1, 6'd45, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [0:0] exp_e;
    @(negedge clk);
    set_field = 2'd2;
    set_val   = 6'd5;
    set_req   = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tsec = 0;
    checks++;
    if ({hr, min, sec, set_ack, set_err, day_wrap, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL reset_mid: got %0d:%0d:%0d ack=%0b err=%0b expected all 0",
               hr, min, sec, set_ack, set_err);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(1'b0);
    tsec = model_load(tsec, 2'd2, 5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!set_ack && n < 8);
    exp_e = exp_q.pop_front();
    checks++;
    if (!set_ack || n != 2 || set_err !== exp_e) begin
      errors++;
      $display("FAIL reset_restart: got ack=%0b err=%0b after %0d cycles expected ack after 2",
               set_ack, set_err, n);
    end
    checks++;
    if ({hr, min, sec} !== hms(tsec)) begin
      errors++;
      $display("FAIL reset_restart_value: got %0d:%0d:%0d expected %0d", hr, min, sec, tsec);
    end
    set_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0] f;
    logic [5:0] v;
    for (int i = 0; i < 6; i++) begin
      f = 2'($urandom_range(0, 2));
      v = 6'($urandom_range(0, (f == 2'd2) ? 23 : 59));
      do_set(f, v, 1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) pulse_tick();
    end
  endtask

  task automatic test_alarm();
    int a0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tsec = 0;
    a0 = alarm_cnt;
`ifdef TOD_ALARM_EN
    do_set(2'd3, 6'd0, 1'b0, 1'b0);
    do_set(2'd3, 6'd1, 1'b0, 1'b0);
    repeat (60) pulse_tick();
    checks++;
    if (alarm_cnt - a0 != 1) begin
      errors++;
      $display("FAIL alarm_count: got %0d pulses expected 1", alarm_cnt - a0);
    end
    checks++;
    if (alarm_at != 60) begin
      errors++;
      $display("FAIL alarm_time: got %0d expected 60", alarm_at);
    end
`else
    do_set(2'd3, 6'd1, 1'b1, 1'b0);
    repeat (60) pulse_tick();
    checks++;
    if (alarm_cnt != a0) begin
      errors++;
      $display("FAIL alarm_off: got %0d pulses expected 0", alarm_cnt - a0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_ticks();
    test_day_wrap();
    test_range_err();
    test_deferred();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_alarm();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
